// File: rtl/cache_mem_responder.sv
// Four-bank interleaved word store answering cache fill/writeback requests.
// Per-bank occupancy counters stall conflicting requests; reads return two cycles after accept.

module cache_mem_bank_ctr #(
  parameter int BANK_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic busy
);
  localparam int CW = $clog2(BANK_CYCLES);

  logic [CW-1:0] cnt, cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (load)             cnt_nxt = CW'(BANK_CYCLES - 1);
    else if (cnt != '0)   cnt_nxt = cnt - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      busy <= (cnt_nxt != '0);
    end
  end
endmodule

module cache_mem_responder #(
  parameter int DW          = 16,
  parameter int AW          = 16,
  parameter int DEPTH_LOG2  = 10,
  parameter int BANK_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd,
  input  logic          wr,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data_in,
  output logic [DW-1:0] data_out,
  output logic          data_valid,
  output logic          stall,
  output logic [3:0]    busy,
  output logic          err
);
  logic                  req, legal, accept;
  logic [1:0]            bank;
  logic [DEPTH_LOG2-1:0] idx;
  logic [DW-1:0]         mem [2**DEPTH_LOG2];
  logic [DW-1:0]         rd_q;
  logic [1:0]            vld_pipe;
  logic                  unused_addr;

  assign bank        = addr[2:1];
  assign idx         = addr[DEPTH_LOG2:1];
  assign unused_addr = ^addr[AW-1:DEPTH_LOG2+1];
  assign req         = rd | wr;
  assign legal       = ~(rd & wr) & ~addr[0];
  assign stall       = req & legal & busy[bank];
  // Gating with rst_n keeps the array untouched while reset is held.
  assign accept      = req & legal & ~busy[bank] & rst_n;

  for (genvar b = 0; b < 4; b++) begin : g_bank
    cache_mem_bank_ctr #(.BANK_CYCLES(BANK_CYCLES)) u_ctr (
      .clk  (clk),
      .rst_n(rst_n),
      .load (accept && (bank == 2'(b))),
      .busy (busy[b])
    );
  end

  // Storage is intentionally not reset; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (accept && wr) mem[idx] <= data_in;
    if (accept && rd) rd_q     <= mem[idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      data_out <= '0;
      err      <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[0], accept & rd};
      err      <= req & ~legal;
      if (vld_pipe[0]) data_out <= rd_q;
    end
  end

  assign data_valid = vld_pipe[1];
endmodule
